// File: rtl/gas_pkg.sv
// Shared constants for the gas controller front-end: channel reset levels,
// lockout state encoding and default timing used by gas_fsm benches.
package gas_pkg;

    localparam logic SAFE_LEVEL = 1'b1;
    localparam logic R_IDLE     = 1'b0;

    localparam int CNT_W_DEF          = 8;
    localparam int DEB_CYCLES_DEF     = 4;
    localparam int GAS_ON_CYCLES_DEF  = 2;
    localparam int GAS_CLR_CYCLES_DEF = 8;
    localparam int REARM_CYCLES_DEF   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } lock_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a saturating stability counter; the output
// follows the synchronised level once it has differed for the direction's threshold.
module input_debouncer #(
    parameter int   CNT_W       = 8,
    parameter int   RISE_CYCLES = 4,
    parameter int   FALL_CYCLES = 4,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out
);

    localparam logic [CNT_W-1:0] RISE_THR = CNT_W'(RISE_CYCLES);
    localparam logic [CNT_W-1:0] FALL_THR = CNT_W'(FALL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;

    // s2 is the level the output would move to, so it selects the threshold
    assign thr = s2 ? RISE_THR : FALL_THR;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1  <= RST_VAL;
            s2  <= RST_VAL;
            out <= RST_VAL;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == out) begin
                cnt <= '0;
            end else if (cnt >= thr - 1'b1) begin
                out <= s2;
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gas_input_conditioner.sv
// Conditions the six raw field inputs for gas_fsm: debounced G/T/P/C/F levels
// and a rate-limited one-cycle RFID authorisation pulse R.
//
//   state | meaning
//   IDLE  | waiting for a debounced card rise
//   LOCK  | pulse issued, further rises ignored until lock_cnt expires
module gas_input_conditioner
    import gas_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int GAS_ON_CYCLES  = GAS_ON_CYCLES_DEF,
    parameter int GAS_CLR_CYCLES = GAS_CLR_CYCLES_DEF,
    parameter int REARM_CYCLES   = REARM_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic g_raw,
    input  logic t_raw,
    input  logic p_raw,
    input  logic c_raw,
    input  logic f_raw,
    input  logic r_raw,
    output logic G,
    output logic T,
    output logic P,
    output logic C,
    output logic F,
    output logic R,
    output logic r_locked
);

    localparam logic [CNT_W-1:0] REARM_VAL = CNT_W'(REARM_CYCLES);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic             r_deb;
    logic             r_deb_q;
    logic             r_rise;
    logic             r_pulse_nxt;
    lock_state_t      state;
    lock_state_t      state_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;

    // gas: falling (leak) is fast, rising (all-clear) is slow
    input_debouncer #(.CNT_W(CNT_W), .RISE_CYCLES(GAS_CLR_CYCLES), .FALL_CYCLES(GAS_ON_CYCLES),
                      .RST_VAL(SAFE_LEVEL))
        u_deb_g (.clk(clk), .rst(rst), .raw(g_raw), .out(G));
    input_debouncer #(.CNT_W(CNT_W), .RISE_CYCLES(DEB_CYCLES), .FALL_CYCLES(DEB_CYCLES),
                      .RST_VAL(SAFE_LEVEL))
        u_deb_t (.clk(clk), .rst(rst), .raw(t_raw), .out(T));
    input_debouncer #(.CNT_W(CNT_W), .RISE_CYCLES(DEB_CYCLES), .FALL_CYCLES(DEB_CYCLES),
                      .RST_VAL(SAFE_LEVEL))
        u_deb_p (.clk(clk), .rst(rst), .raw(p_raw), .out(P));
    input_debouncer #(.CNT_W(CNT_W), .RISE_CYCLES(DEB_CYCLES), .FALL_CYCLES(DEB_CYCLES),
                      .RST_VAL(SAFE_LEVEL))
        u_deb_c (.clk(clk), .rst(rst), .raw(c_raw), .out(C));
    input_debouncer #(.CNT_W(CNT_W), .RISE_CYCLES(DEB_CYCLES), .FALL_CYCLES(DEB_CYCLES),
                      .RST_VAL(SAFE_LEVEL))
        u_deb_f (.clk(clk), .rst(rst), .raw(f_raw), .out(F));
    input_debouncer #(.CNT_W(CNT_W), .RISE_CYCLES(DEB_CYCLES), .FALL_CYCLES(DEB_CYCLES),
                      .RST_VAL(R_IDLE))
        u_deb_r (.clk(clk), .rst(rst), .raw(r_raw), .out(r_deb));

    assign r_rise   = r_deb & ~r_deb_q;
    assign r_locked = (state == LOCK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_deb_q  <= R_IDLE;
            state    <= IDLE;
            lock_cnt <= '0;
            R        <= 1'b0;
        end else begin
            r_deb_q  <= r_deb;
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            R        <= r_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        r_pulse_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (r_rise) begin
                    r_pulse_nxt  = 1'b1;
                    lock_cnt_nxt = REARM_VAL;
                    state_nxt    = LOCK;
                end
            end
            LOCK: begin
                // leave on the edge where the count reaches zero
                if (lock_cnt <= ONE) begin
                    lock_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    lock_cnt_nxt = lock_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/gas_input_conditioner.md
Name: gas_input_conditioner

Overview:
Upstream front-end for gas_fsm. It takes the six raw, asynchronous field signals: gas-safe, temperature-ok, PLN-power-ok, fan-current-ok, flame-ok and RFID-present. It synchronises and debounces each one and drives the clean G/T/P/C/F levels and a single-cycle R pulse straight into the gas_fsm inputs. The gas-safe debounce is asymmetric: leak detection is fast and the all-clear is slow. RFID authorisation is rate-limited by a lockout window.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required to change T/P/C/F/R outputs
GAS_ON_CYCLES, 2, stable-low cycles required to drop G (leak)
GAS_CLR_CYCLES, 8, stable-high cycles required to raise G (clear)
REARM_CYCLES, 16, R lockout length after a pulse
CNT_W, 8, counter width; every cycle parameter must be ≥1 and <2^CNT_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
g_raw  in  1  gas sensor, 1 = safe, asynchronous
t_raw  in  1  temperature ok, asynchronous
p_raw  in  1  PLN mains present, asynchronous
c_raw  in  1  fan current present, asynchronous
f_raw  in  1  flame sensor ok, asynchronous
r_raw  in  1  RFID authorised card present (level), asynchronous
G  out  1  debounced gas-safe to gas_fsm
T  out  1  debounced temperature-ok
P  out  1  debounced PLN-ok
C  out  1  debounced fan-current-ok
F  out  1  debounced flame-ok
R  out  1  one-cycle reset-authorisation pulse
r_locked  out  1  high while the R lockout is active

Behaviour:
- Reset (rst==0 at a clk edge): G=T=P=C=F=1, R=0, r_locked=0. All sync flops for g..f load 1, r sync flops load 0, and all counters clear. No output edge may be produced on the first cycles after reset release unless the raw input actually differs. Reset mid-debounce discards the partial count.
- Each input passes through a 2-flop synchroniser. s2 is the synchronised value.
- Debounce per channel:
  - cnt clears whenever s2 == current output.
  - While s2 != output, cnt increments by 1 each cycle.
  - When cnt reaches the threshold (N-1 → N), the output takes s2 on that same edge and cnt clears.
  - Total latency from the first edge sampling the new raw level to the output change is N+2 cycles.
  - A pulse shorter than N cycles (after sync) never reaches the output.
  - Counters saturate and never wrap.
- Thresholds per channel:
  - G: GAS_ON_CYCLES when s2=0 and output=1. GAS_CLR_CYCLES when s2=1 and output=0.
  - T, P, C and F: DEB_CYCLES.
- R path: the r channel is debounced with DEB_CYCLES into an internal level r_deb. A rising edge of r_deb (0→1) produces R=1 for exactly one cycle, on the cycle after r_deb rises. R latency is DEB_CYCLES+3 cycles.
- Lockout FSM: states IDLE and LOCK.
  - IDLE: on an r_deb rise, emit R, load the lock counter with REARM_CYCLES and go to LOCK.
  - LOCK: r_locked=1. The counter decrements each cycle; at 0, return to IDLE.
  - r_deb rises while in LOCK are dropped, not queued.
  - Holding the card does not retrigger. A new pulse requires r_deb to fall and rise again after the lockout ends.
- Channels are fully independent. Simultaneous changes on several inputs each complete on their own latency.
- Sub-module input_debouncer is instantiated 6×.

Decomposition:
- Package gas_pkg: reset levels of each channel (SAFE_LEVEL=1'b1, R_IDLE=1'b0), lockout state encoding (IDLE, LOCK) and default cycle constants shared with gas_fsm benches.
- Sub-module input_debouncer:
  - Parameters: CNT_W, RISE_CYCLES, FALL_CYCLES, RST_VAL.
  - Ports: clk, rst, raw, out.
  - Contains the synchroniser and the counter. Symmetric channels pass RISE=FALL=DEB_CYCLES.
- Top level: instances, R edge detect and the lockout FSM.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all raw inputs toggling → G..F=1, R=0, r_locked=0 throughout. After release with g..f_raw=1 and r_raw=0, outputs stay unchanged for 20 cycles.
- P debounce: p_raw 1→0 held → P falls exactly 6 cycles later. A 3-cycle p_raw low glitch → P stays 1.
- Gas asymmetry: g_raw 1→0 held → G falls after 4 cycles. g_raw 0→1 held → G rises after 10 cycles. A 7-cycle high blip while G=0 → G stays 0.
- RFID: r_raw held high for 40 cycles → exactly one R pulse at 7 cycles, with r_locked high for 16 cycles. Releasing r_raw and re-presenting the card after the lockout → second pulse.
- Lockout drop: a card pulse, release, then a re-present that makes r_deb rise inside the lockout → no second R pulse. A re-present after r_locked falls → pulse.
- Reset mid-operation: drop rst during a P count at cnt=3 → P=1 and the count is discarded. After release with p_raw still 0 → full 6-cycle latency again.
